// File: rtl/label_stats.sv
// label_stats: accumulates per-label bounding box and area over a frame, then streams one record per live label.
// Optional build macro LABEL_STATS_CENTROID_EN adds saturating per-label coordinate sums (obj_sum_x/obj_sum_y).
module label_stats #(
    parameter int LABEL_W = 8,
    parameter int COORD_W = 11,
    parameter int AREA_W  = 22,
    parameter int SUM_W   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [LABEL_W-1:0] label,
    input  logic               frame_end,
    output logic               busy,
    output logic               dropped,
    // Record handshake: a record transfers on a rising clk edge where obj_valid && obj_ready;
    // once obj_valid is high the record is frozen and obj_valid stays high until that transfer.
    output logic               obj_valid,
    input  logic               obj_ready,
    output logic [LABEL_W-1:0] obj_label,
    output logic [COORD_W-1:0] obj_min_x,
    output logic [COORD_W-1:0] obj_max_x,
    output logic [COORD_W-1:0] obj_min_y,
    output logic [COORD_W-1:0] obj_max_y,
    output logic [AREA_W-1:0]  obj_area,
    output logic               obj_last,
`ifdef LABEL_STATS_CENTROID_EN
    output logic [SUM_W-1:0]   obj_sum_x,
    output logic [SUM_W-1:0]   obj_sum_y,
`endif
    output logic               state_dbg
);

    localparam int NUM_LABELS = 1 << LABEL_W;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [AREA_W-1:0]  AREA_MAX  = '1;

    typedef enum logic {ACCUM, DUMP} state_t;

    state_t               state_q, state_d;
    logic [LABEL_W-1:0]   idx_q, idx_d;
    logic                 load_rec, advance;
    logic [COORD_W-1:0]   x_q, y_q, cur_x, cur_y;
    logic                 pix_acc, upd;
    logic [NUM_LABELS-1:0] valid_q;
    logic [NUM_LABELS-1:0] above_mask;

    logic [COORD_W-1:0] min_x_q [NUM_LABELS];
    logic [COORD_W-1:0] max_x_q [NUM_LABELS];
    logic [COORD_W-1:0] min_y_q [NUM_LABELS];
    logic [COORD_W-1:0] max_y_q [NUM_LABELS];
    logic [AREA_W-1:0]  area_q  [NUM_LABELS];

    assign busy      = (state_q == DUMP);
    assign state_dbg = (state_q == DUMP);
    assign pix_acc   = (state_q == ACCUM) && en;
    assign upd       = pix_acc && (label != '0);

    // Coordinate of the pixel presented this cycle; x_q/y_q hold the previous pixel's position.
    always_comb begin
        cur_x = x_q;
        cur_y = y_q;
        if (vsync) begin
            cur_x = '0;
            cur_y = '0;
        end else if (hsync) begin
            cur_x = '0;
            cur_y = (y_q == COORD_MAX) ? y_q : y_q + COORD_W'(1);
        end else begin
            cur_x = (x_q == COORD_MAX) ? x_q : x_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load_rec = 1'b0;
        advance  = 1'b0;
        case (state_q)
            ACCUM: begin
                if (frame_end) begin
                    state_d = DUMP;
                    idx_d   = LABEL_W'(1);
                end
            end
            DUMP: begin
                if (obj_valid) advance = obj_ready;
                else if (valid_q[idx_q]) load_rec = 1'b1;
                else advance = 1'b1;
                if (advance) begin
                    idx_d = idx_q + LABEL_W'(1);
                    if (&idx_q) state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            dropped <= 1'b0;
        end else begin
            if (pix_acc) begin
                x_q <= cur_x;
                y_q <= cur_y;
            end else if (state_q == DUMP && state_d == ACCUM) begin
                x_q <= '0;
                y_q <= '0;
            end
            if (state_q == DUMP && en) dropped <= 1'b1;
        end
    end

    // Only the valid bits need reset; table contents are ignored while their valid bit is clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            if (upd) valid_q[label] <= 1'b1;
            if (advance) valid_q[idx_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (upd) begin
            if (!valid_q[label]) begin
                min_x_q[label] <= cur_x;
                max_x_q[label] <= cur_x;
                min_y_q[label] <= cur_y;
                max_y_q[label] <= cur_y;
                area_q[label]  <= AREA_W'(1);
            end else begin
                if (cur_x < min_x_q[label]) min_x_q[label] <= cur_x;
                if (cur_x > max_x_q[label]) max_x_q[label] <= cur_x;
                if (cur_y < min_y_q[label]) min_y_q[label] <= cur_y;
                if (cur_y > max_y_q[label]) max_y_q[label] <= cur_y;
                if (area_q[label] != AREA_MAX) area_q[label] <= area_q[label] + AREA_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obj_valid <= 1'b0;
            obj_label <= '0;
            obj_min_x <= '0;
            obj_max_x <= '0;
            obj_min_y <= '0;
            obj_max_y <= '0;
            obj_area  <= '0;
        end else if (load_rec) begin
            obj_valid <= 1'b1;
            obj_label <= idx_q;
            obj_min_x <= min_x_q[idx_q];
            obj_max_x <= max_x_q[idx_q];
            obj_min_y <= min_y_q[idx_q];
            obj_max_y <= max_y_q[idx_q];
            obj_area  <= area_q[idx_q];
        end else if (obj_valid && obj_ready) begin
            obj_valid <= 1'b0;
        end
    end

    assign above_mask = ({NUM_LABELS{1'b1}} << obj_label) << 1;
    assign obj_last   = obj_valid && ((valid_q & above_mask) == '0);

`ifdef LABEL_STATS_CENTROID_EN
    logic [SUM_W-1:0] sum_x_q [NUM_LABELS];
    logic [SUM_W-1:0] sum_y_q [NUM_LABELS];
    logic [SUM_W:0]   sum_x_ext, sum_y_ext;

    assign sum_x_ext = {1'b0, sum_x_q[label]} + (SUM_W+1)'(cur_x);
    assign sum_y_ext = {1'b0, sum_y_q[label]} + (SUM_W+1)'(cur_y);

    always_ff @(posedge clk) begin
        if (upd) begin
            if (!valid_q[label]) begin
                sum_x_q[label] <= SUM_W'(cur_x);
                sum_y_q[label] <= SUM_W'(cur_y);
            end else begin
                sum_x_q[label] <= sum_x_ext[SUM_W] ? {SUM_W{1'b1}} : sum_x_ext[SUM_W-1:0];
                sum_y_q[label] <= sum_y_ext[SUM_W] ? {SUM_W{1'b1}} : sum_y_ext[SUM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obj_sum_x <= '0;
            obj_sum_y <= '0;
        end else if (load_rec) begin
            obj_sum_x <= sum_x_q[idx_q];
            obj_sum_y <= sum_y_q[idx_q];
        end
    end
`endif

endmodule

// File: tb/tb_label_stats.sv
// Self-checking bench for label_stats: frames are described as label grids and the expected
// records are derived from the grids directly, then compared in order against the dump stream.
module tb_label_stats;
    localparam int LABEL_W = 8;
    localparam int COORD_W = 11;
    localparam int AREA_W  = 22;
    localparam int SUM_W   = 32;
    localparam int REC_W   = LABEL_W + 4 * COORD_W + AREA_W + 2 * SUM_W;
    localparam int MAX_W   = 100;
    localparam int MAX_H   = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               en = 1'b0;
    logic               hsync = 1'b0;
    logic               vsync = 1'b0;
    logic [LABEL_W-1:0] label = '0;
    logic               frame_end = 1'b0;
    logic               obj_ready = 1'b0;
    logic               busy, dropped, obj_valid, obj_last, state_dbg;
    logic [LABEL_W-1:0] obj_label;
    logic [COORD_W-1:0] obj_min_x, obj_max_x, obj_min_y, obj_max_y;
    logic [AREA_W-1:0]  obj_area;
    logic [SUM_W-1:0]   sum_x_o, sum_y_o;

    logic [REC_W-1:0]   exp_q[$];
    logic [7:0]         grid [MAX_H][MAX_W];
    int                 n_checks = 0;
    int                 n_pass = 0;

    label_stats dut (
        .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync),
        .label(label), .frame_end(frame_end), .busy(busy), .dropped(dropped),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_label(obj_label),
        .obj_min_x(obj_min_x), .obj_max_x(obj_max_x), .obj_min_y(obj_min_y),
        .obj_max_y(obj_max_y), .obj_area(obj_area), .obj_last(obj_last),
`ifdef LABEL_STATS_CENTROID_EN
        .obj_sum_x(sum_x_o), .obj_sum_y(sum_y_o),
`endif
        .state_dbg(state_dbg)
    );

`ifndef LABEL_STATS_CENTROID_EN
    assign sum_x_o = '0;
    assign sum_y_o = '0;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [REC_W-1:0] cur_rec();
        return {obj_label, obj_min_x, obj_max_x, obj_min_y, obj_max_y, obj_area, sum_x_o, sum_y_o};
    endfunction

    // ---------------- reference model ----------------
    task automatic clear_grid();
        for (int r = 0; r < MAX_H; r++)
            for (int c = 0; c < MAX_W; c++) grid[r][c] = 8'd0;
    endtask

    task automatic fill_random(input int w, input int h);
        logic [7:0] pal [4];
        pal[0] = 8'd1;
        pal[1] = 8'd255;
        pal[2] = 8'($urandom_range(2, 254));
        pal[3] = 8'($urandom_range(2, 254));
        clear_grid();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                grid[r][c] = ($urandom_range(0, 1) == 0) ? 8'd0 : pal[$urandom_range(0, 3)];
    endtask

    // Pixel (row r, column c) sits at x=c, y=r; one record per label present, ascending.
    task automatic build_expected(input int w, input int h);
        for (int lab = 1; lab < 256; lab++) begin
            bit found;
            int mnx, mxx, mny, mxy, ar;
            longint sx, sy;
            found = 0; mnx = 0; mxx = 0; mny = 0; mxy = 0; ar = 0; sx = 0; sy = 0;
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    if (int'(grid[r][c]) == lab) begin
                        if (!found) begin
                            mnx = c; mxx = c; mny = r; mxy = r;
                        end
                        found = 1;
                        if (c < mnx) mnx = c;
                        if (c > mxx) mxx = c;
                        if (r < mny) mny = r;
                        if (r > mxy) mxy = r;
                        ar++;
                        sx += c;
                        sy += r;
                    end
                end
            end
`ifndef LABEL_STATS_CENTROID_EN
            sx = 0;
            sy = 0;
`endif
            if (found)
                exp_q.push_back({LABEL_W'(lab), COORD_W'(mnx), COORD_W'(mxx), COORD_W'(mny),
                                 COORD_W'(mxy), AREA_W'(ar), SUM_W'(sx), SUM_W'(sy)});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_frame(input int w, input int h, input bit fe_last);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    en = 1'b0;
                    vsync = 1'($urandom_range(0, 1));
                    hsync = 1'($urandom_range(0, 1));
                    label = 8'($urandom_range(0, 255));
                    @(posedge clk); #1;
                end
                en = 1'b1;
                vsync = (r == 0 && c == 0);
                hsync = (c == 0 && r != 0) || (r == 0 && c == 0 && $urandom_range(0, 1) == 1);
                label = grid[r][c];
                frame_end = fe_last && (r == h - 1) && (c == w - 1);
                @(posedge clk); #1;
            end
        end
        en = 1'b0; vsync = 1'b0; hsync = 1'b0; label = '0;
        if (!fe_last) begin
            frame_end = 1'b1;
            @(posedge clk); #1;
        end
        frame_end = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for the first 10 valid cycles
    task automatic collect_dump(input int mode, input bit inject, output int busy_cycles,
                                output int valid_cycles);
        logic [REC_W:0]   held;
        logic [REC_W-1:0] exp;
        bit               holding;
        int               guard;
        holding = 0; guard = 0; busy_cycles = 0; valid_cycles = 0; held = '0;
        check("busy_start", busy, 1);
        while (busy && guard < 2000) begin
            busy_cycles++;
            guard++;
            if (holding) begin
                check("valid_held", obj_valid, 1);
                check("hold_stable", {cur_rec(), obj_last}, held);
            end
            case (mode)
                0: obj_ready = 1'b1;
                1: obj_ready = 1'($urandom_range(0, 1));
                default: obj_ready = (valid_cycles >= 10);
            endcase
            if (inject && $urandom_range(0, 3) == 0) begin
                en = 1'b1;
                vsync = 1'($urandom_range(0, 1));
                label = 8'($urandom_range(1, 255));
            end else begin
                en = 1'b0;
                vsync = 1'b0;
            end
            holding = 0;
            if (obj_valid) begin
                valid_cycles++;
                if (obj_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_record", exp_q.size(), 1);
                    end else begin
                        exp = exp_q.pop_front();
                        check("record", cur_rec(), exp);
                        check("obj_last", obj_last, exp_q.size() == 0);
                    end
                end else begin
                    holding = 1;
                    held = {cur_rec(), obj_last};
                end
            end
            @(posedge clk); #1;
        end
        en = 1'b0; vsync = 1'b0; label = '0; obj_ready = 1'b0;
        check("dump_done", busy, 0);
        check("records_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bc, vc, w, h;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_dropped", dropped, 0);
        check("rst_valid", obj_valid, 0);
        check("rst_last", obj_last, 0);
        check("rst_record", cur_rec(), 0);

        // empty frame
        clear_grid();
        build_expected(4, 4);
        drive_frame(4, 4, 0);
        collect_dump(0, 0, bc, vc);
        check("empty_busy_cycles", bc, 255);
        check("empty_valid_cycles", vc, 0);

        // single small object
        clear_grid();
        grid[1][2] = 8'd5; grid[1][3] = 8'd5; grid[2][2] = 8'd5;
        build_expected(8, 4);
        drive_frame(8, 4, 0);
        collect_dump(0, 0, bc, vc);
        check("one_obj_valid_cycles", vc, 1);

        // two objects with a stalled consumer; frame_end arrives with the last pixel
        clear_grid();
        grid[0][1] = 8'd3; grid[0][2] = 8'd3; grid[2][6] = 8'd9; grid[3][6] = 8'd9;
        grid[3][7] = 8'd9;
        build_expected(8, 4);
        drive_frame(8, 4, 1);
        collect_dump(2, 0, bc, vc);

        // long run of one label
        clear_grid();
        for (int c = 0; c < 100; c++) grid[0][c] = 8'd7;
        build_expected(100, 1);
        drive_frame(100, 1, 0);
        collect_dump(1, 0, bc, vc);

        // pixels offered while busy are dropped and do not leak into the next frame
        fill_random(16, 6);
        build_expected(16, 6);
        drive_frame(16, 6, 0);
        collect_dump(1, 1, bc, vc);
        check("dropped_set", dropped, 1);
        fill_random(20, 5);
        build_expected(20, 5);
        drive_frame(20, 5, 0);
        collect_dump(1, 0, bc, vc);
        check("dropped_sticky", dropped, 1);

        // reset in the middle of a dump
        clear_grid();
        grid[0][0] = 8'd1; grid[1][1] = 8'd200; grid[2][3] = 8'd200;
        drive_frame(4, 4, 0);
        obj_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pre_rst_valid", obj_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", obj_valid, 0);
        check("mid_rst_last", obj_last, 0);
        check("mid_rst_dropped", dropped, 0);
        check("mid_rst_record", cur_rec(), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        fill_random(12, 4);
        build_expected(12, 4);
        drive_frame(12, 4, 0);
        collect_dump(1, 0, bc, vc);

        // randomized frames
        repeat (6) begin
            w = $urandom_range(2, 40);
            h = $urandom_range(1, MAX_H);
            fill_random(w, h);
            build_expected(w, h);
            drive_frame(w, h, 1'($urandom_range(0, 1)));
            collect_dump(1, 0, bc, vc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
